// File: rtl/key_pkg.sv
// Shared definitions for the pushbutton conditioner: per-key state type and default timing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package key_pkg;

    localparam int NUM_KEYS = 3;

    // Defaults assume a 50 MHz clk.
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;   // 20 ms
    localparam int DEF_REPEAT_DELAY    = 25_000_000;  // 0.5 s
    localparam int DEF_REPEAT_PERIOD   = 5_000_000;   // 0.1 s
    localparam logic [NUM_KEYS-1:0] DEF_REPEAT_MASK = 3'b011;

    // Accepted-level state of one key. PRESS_DB / RELEASE_DB are the
    // "candidate change" states in which the debounce counter runs.
    typedef enum logic [1:0] {
        RELEASED   = 2'd0,
        PRESS_DB   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } key_state_t;

    // Counter width shared by the debounce and repeat counters: one bit
    // more than the largest timing parameter needs. The extra bit lets the
    // repeat counter reach DELAY+PERIOD-1 without wrapping.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 2) m = 2;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/key_pulse_conditioner_if.sv
// Bundle between the raw pushbuttons and the speed-control stage.
// Latency: n/a (wires only).
// Backpressure: none; pulses are fire-and-forget, held is a level.
//   KEY    : raw active-low buttons (asynchronous, bouncing)
//   key_0  : slow-down pulse, key_1 : speed-up pulse, key_2 : speed-reset pulse
//   held   : per-key accepted-pressed level
interface key_pulse_conditioner_if;
    import key_pkg::*;

    logic [NUM_KEYS-1:0] KEY;
    logic                key_0;
    logic                key_1;
    logic                key_2;
    logic [NUM_KEYS-1:0] held;

    // Board / stimulus side: drives the buttons, consumes the pulses.
    modport master (
        output KEY,
        input  key_0,
        input  key_1,
        input  key_2,
        input  held
    );

    // Conditioner side.
    modport slave (
        input  KEY,
        output key_0,
        output key_1,
        output key_2,
        output held
    );
endinterface

// File: rtl/key_debounce_fsm.sv
// One key: debounce a synchronized pressed level, emit a pulse on acceptance and on auto-repeat.
// Latency: pulse registered, first cycle in PRESSED (DEBOUNCE_CYCLES+1 pressed samples after the first).
// Backpressure: none; pulse is a single-cycle strobe, held follows the accepted level.
//   clk, reset : clock, asynchronous active-high reset
//   pressed    : synchronized, active-high key level
//   pulse      : one-cycle press / repeat strobe
//   held       : high in PRESSED and RELEASE_DB
module key_debounce_fsm
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)
)(
    input  logic clk,
    input  logic reset,
    input  logic pressed,
    output logic pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    // The repeat counter is compared one cycle early so the registered
    // pulse lines up with the cycle in which the count reaches the target.
    localparam logic [CNT_W-1:0] REP_FIRST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_DELAY + REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REPEAT_DELAY);

    key_state_t       state, state_nxt;
    logic [CNT_W-1:0] db_cnt, db_cnt_nxt;
    logic [CNT_W-1:0] rep_cnt, rep_cnt_nxt;
    logic             pulse_q, pulse_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RELEASED;
            db_cnt  <= '0;
            rep_cnt <= '0;
            pulse_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            db_cnt  <= db_cnt_nxt;
            rep_cnt <= rep_cnt_nxt;
            pulse_q <= pulse_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        db_cnt_nxt  = db_cnt;
        rep_cnt_nxt = rep_cnt;
        pulse_nxt   = 1'b0;

        unique case (state)
            RELEASED: begin
                if (pressed) begin
                    state_nxt  = PRESS_DB;
                    db_cnt_nxt = '0;
                end
            end

            PRESS_DB: begin
                if (!pressed) begin
                    state_nxt = RELEASED;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt   = PRESSED;
                    rep_cnt_nxt = '0;
                    pulse_nxt   = 1'b1;
                end else begin
                    db_cnt_nxt = sat_inc(db_cnt);
                end
            end

            PRESSED: begin
                // Counts every cycle spent in PRESSED, including the one in
                // which a release is first seen. Once past the first repeat
                // it cycles DELAY..DELAY+PERIOD-1 so it never runs away.
                if (REPEAT_EN && rep_cnt == REP_LAST) begin
                    rep_cnt_nxt = REP_RELOAD;
                end else begin
                    rep_cnt_nxt = sat_inc(rep_cnt);
                end

                if (!pressed) begin
                    state_nxt  = RELEASE_DB;
                    db_cnt_nxt = '0;
                end else if (REPEAT_EN && (rep_cnt == REP_FIRST || rep_cnt == REP_LAST)) begin
                    pulse_nxt = 1'b1;
                end
            end

            RELEASE_DB: begin
                // rep_cnt is frozen here so a bounce back resumes the cadence.
                if (pressed) begin
                    state_nxt = PRESSED;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt = RELEASED;
                end else begin
                    db_cnt_nxt = sat_inc(db_cnt);
                end
            end

            default: begin
                state_nxt = RELEASED;
            end
        endcase
    end

    assign pulse = pulse_q;
    assign held  = (state == PRESSED) || (state == RELEASE_DB);

endmodule

// File: rtl/key_pulse_conditioner.sv
// Turns three raw, bouncing, active-low pushbuttons into clean press/repeat pulses and held levels.
// Latency: KEY edge to pulse = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles for a clean edge.
// Backpressure: none; keys are independent and simultaneous presses pulse together.
//   clk, reset : clock, asynchronous active-high reset
//   kif.KEY    : raw buttons in; kif.key_0/1/2 pulses out; kif.held levels out
module key_pulse_conditioner
    import key_pkg::*;
#(
    parameter int                  DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int                  REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int                  REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter logic [NUM_KEYS-1:0] REPEAT_MASK     = DEF_REPEAT_MASK
)(
    input  logic                    clk,
    input  logic                    reset,
    key_pulse_conditioner_if.slave  kif
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

    logic [NUM_KEYS-1:0] sync_1;
    logic [NUM_KEYS-1:0] sync_2;
    logic [NUM_KEYS-1:0] pressed;
    logic [NUM_KEYS-1:0] pulse;
    logic [NUM_KEYS-1:0] held;

    // Synchronizer resets to all-ones: the buttons are active-low, so this
    // is "released" and a key held through reset is seen as a fresh press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= '1;
            sync_2 <= '1;
        end else begin
            sync_1 <= kif.KEY;
            sync_2 <= sync_1;
        end
    end

    assign pressed = ~sync_2;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_fsm #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[i]),
            .CNT_W           (CNT_W)
        ) u_fsm (
            .clk     (clk),
            .reset   (reset),
            .pressed (pressed[i]),
            .pulse   (pulse[i]),
            .held    (held[i])
        );
    end

    assign kif.key_0 = pulse[0];
    assign kif.key_1 = pulse[1];
    assign kif.key_2 = pulse[2];
    assign kif.held  = held;

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Bench for key_pulse_conditioner: table vectors, directed corner sequences, random run against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_key_pulse_conditioner;

    localparam int       TB_DB     = 4;
    localparam int       TB_DELAY  = 20;
    localparam int       TB_PERIOD = 8;
    localparam bit [2:0] TB_MASK   = 3'b011;

    logic clk;
    logic reset;

    key_pulse_conditioner_if kif ();

    key_pulse_conditioner #(
        .DEBOUNCE_CYCLES (TB_DB),
        .REPEAT_DELAY    (TB_DELAY),
        .REPEAT_PERIOD   (TB_PERIOD),
        .REPEAT_MASK     (TB_MASK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kif   (kif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    // A key's accepted level flips once TB_DB+1 consecutive synchronized
    // samples disagree with it. Time spent accepted-pressed with no
    // disagreement pending is "dwell"; repeats fire whenever dwell sits at
    // TB_DELAY + k*TB_PERIOD and the key is still stably pressed.
    typedef struct {
        bit acc;
        int run;
        int dwell;
        bit fire;
    } mkey_t;

    function automatic mkey_t mstep(mkey_t k, bit smp, bit en);
        mkey_t n;
        bit    stable_before;
        n = k;
        n.fire = 1'b0;
        stable_before = k.acc && (k.run == 0);
        if (stable_before) n.dwell = k.dwell + 1;
        if (smp != k.acc) begin
            n.run = k.run + 1;
            if (n.run == TB_DB + 1) begin
                n.acc = smp;
                n.run = 0;
                if (smp) begin
                    n.dwell = 0;
                    n.fire  = 1'b1;
                end
            end
        end else begin
            n.run = 0;
        end
        if (stable_before && n.acc && n.run == 0 && en &&
            n.dwell >= TB_DELAY && ((n.dwell - TB_DELAY) % TB_PERIOD) == 0)
            n.fire = 1'b1;
        return n;
    endfunction

    mkey_t      mk [3];
    logic [2:0] m_s1, m_s2;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) mk[i] <= '{1'b0, 0, 0, 1'b0};
            m_s1 <= 3'b111;
            m_s2 <= 3'b111;
        end else begin
            for (int i = 0; i < 3; i++) mk[i] <= mstep(mk[i], ~m_s2[i], TB_MASK[i]);
            m_s2 <= m_s1;
            m_s1 <= kif.KEY;
        end
    end

    bit chk_en = 1'b0;
    int nprint = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            logic [5:0] act, exp;
            act = {kif.key_2, kif.key_1, kif.key_0, kif.held};
            exp = {mk[2].fire, mk[1].fire, mk[0].fire, mk[2].acc, mk[1].acc, mk[0].acc};
            total++;
            if (act !== exp) begin
                bad++;
                if (nprint < 20) begin
                    nprint++;
                    $display("FAIL model_cmp t=%0t pulses=%b held=%b want pulses=%b held=%b",
                             $time, act[5:3], act[2:0], exp[5:3], exp[2:0]);
                end
            end
        end
    end

    // ---------------- pulse / held recorder ----------------
    int         edge_n = 0;
    int         t0     = 0;
    int         q0[$], q1[$], q2[$];
    logic [2:0] hh [128];

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(negedge clk) begin
        int rel;
        rel = edge_n - t0;
        if (kif.key_0) q0.push_back(rel);
        if (kif.key_1) q1.push_back(rel);
        if (kif.key_2) q2.push_back(rel);
        if (rel >= 0 && rel < 128) hh[rel] = kif.held;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start();
        q0.delete();
        q1.delete();
        q2.delete();
        for (int k = 0; k < 128; k++) hh[k] = 3'b000;
        t0 = edge_n;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return -1;
    endfunction

    function automatic int count_low(input int b, input int from, input int to);
        int n;
        n = 0;
        for (int k = from; k <= to; k++) if (hh[k][b] !== 1'b1) n++;
        return n;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0] key_low;
        int         hold;
        int         n0;
        int         n1;
        int         n2;
        logic [2:0] held_end;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int         rem [3];
        logic [2:0] kbits;
        logic [2:0] h;

        tbl[0] = '{3'b001, 10, 1, 0, 0, 3'b001};
        tbl[1] = '{3'b010, 30, 0, 2, 0, 3'b010};
        tbl[2] = '{3'b100, 60, 0, 0, 1, 3'b100};
        tbl[3] = '{3'b011, 40, 3, 3, 0, 3'b011};
        tbl[4] = '{3'b111,  4, 0, 0, 0, 3'b000};
        tbl[5] = '{3'b001,  5, 1, 0, 0, 3'b000};
        tbl[6] = '{3'b010, 24, 0, 1, 0, 3'b010};
        tbl[7] = '{3'b010, 25, 0, 2, 0, 3'b010};

        reset   = 1'b1;
        kif.KEY = 3'b111;
        cyc(1);
        chk_en = 1'b1;
        cyc(2);
        check("reset_held", int'(kif.held), 0);
        check("reset_pulses", int'({kif.key_2, kif.key_1, kif.key_0}), 0);
        reset = 1'b0;
        cyc(5);

        for (int v = 0; v < 8; v++) begin
            start();
            kif.KEY = ~tbl[v].key_low;
            cyc(tbl[v].hold);
            h = kif.held;
            kif.KEY = 3'b111;
            cyc(20);
            check($sformatf("tbl%0d_n0", v), q0.size(), tbl[v].n0);
            check($sformatf("tbl%0d_n1", v), q1.size(), tbl[v].n1);
            check($sformatf("tbl%0d_n2", v), q2.size(), tbl[v].n2);
            check($sformatf("tbl%0d_held", v), int'(h), int'(tbl[v].held_end));
        end

        // Clean press of KEY[0]: one pulse exactly 7 cycles after the edge.
        start();
        kif.KEY = 3'b110;
        cyc(10);
        kif.KEY = 3'b111;
        cyc(20);
        check("clean_cnt", q0.size(), 1);
        check("clean_time", qat(q0, 0), 7);
        check("clean_other", q1.size() + q2.size(), 0);

        // Bouncing KEY[1], then stable: accept at 16, repeats at 36 and 44.
        start();
        for (int j = 0; j < 3; j++) begin
            kif.KEY = 3'b101;
            cyc(2);
            kif.KEY = 3'b111;
            cyc(1);
        end
        kif.KEY = 3'b101;
        cyc(40);
        kif.KEY = 3'b111;
        cyc(20);
        check("bounce_cnt", q1.size(), 3);
        check("bounce_t0", qat(q1, 0), 16);
        check("bounce_t1", qat(q1, 1), 36);
        check("bounce_t2", qat(q1, 2), 44);

        // KEY[2] held long: one pulse, no repeat, held until release debounce ends.
        start();
        kif.KEY = 3'b011;
        cyc(60);
        kif.KEY = 3'b111;
        cyc(20);
        check("k2_cnt", q2.size(), 1);
        check("k2_time", qat(q2, 0), 7);
        check("k2_held_gaps", count_low(2, 7, 66), 0);
        check("k2_held_pre", int'(hh[6][2]), 0);
        check("k2_held_drop", int'(hh[67][2]), 0);

        // KEY[0] and KEY[1] together: pulses in the same cycle.
        start();
        kif.KEY = 3'b100;
        cyc(10);
        kif.KEY = 3'b111;
        cyc(20);
        check("simul_cnt0", q0.size(), 1);
        check("simul_cnt1", q1.size(), 1);
        check("simul_t0", qat(q0, 0), 7);
        check("simul_t1", qat(q1, 0), 7);

        // Reset during press debounce, key held across reset release.
        start();
        kif.KEY = 3'b110;
        cyc(4);
        reset = 1'b1;
        #1;
        check("rst_mid_held", int'(kif.held), 0);
        cyc(2);
        reset = 1'b0;
        check("rst_mid_nopulse", q0.size(), 0);
        start();
        cyc(10);
        kif.KEY = 3'b111;
        cyc(20);
        check("rst_after_cnt", q0.size(), 1);
        check("rst_after_time", qat(q0, 0), 7);

        // Two-cycle release glitch on KEY[1] while pressed.
        start();
        kif.KEY = 3'b101;
        cyc(10);
        kif.KEY = 3'b111;
        cyc(2);
        kif.KEY = 3'b101;
        cyc(28);
        kif.KEY = 3'b111;
        cyc(20);
        check("glitch_cnt", q1.size(), 3);
        check("glitch_t0", qat(q1, 0), 7);
        check("glitch_t1", qat(q1, 1), 29);
        check("glitch_t2", qat(q1, 2), 37);
        check("glitch_held_gaps", count_low(1, 7, 46), 0);

        // Random level runs on all keys with occasional resets.
        kbits = 3'b111;
        for (int i = 0; i < 3; i++) rem[i] = $urandom_range(1, 50);
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (rem[i] == 0) begin
                    kbits[i] = ~kbits[i];
                    rem[i]   = $urandom_range(1, 50);
                end
                rem[i]--;
            end
            kif.KEY = kbits;
            reset   = ($urandom_range(0, 1499) == 0);
            cyc(1);
        end
        reset   = 1'b0;
        kif.KEY = 3'b111;
        cyc(30);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
